// File: rtl/tdm_tx.sv
// tdm_tx: NUM_CH-slot TDM serial audio transmitter with a one-frame holding buffer, MSB-first.
// Define TDM_TX_I2S_DELAY_EN for the I2S-style one-bit data delay after fsync (default: DSP/left-justified).
module tdm_tx #(
    parameter int AUDIO_DW = 32,
    parameter int SLOT_W   = 32,
    parameter int NUM_CH   = 8
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic [NUM_CH*AUDIO_DW-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       fsync,
    output logic                       sdata,
    output logic                       frame_start,
    output logic                       underrun
);
    localparam int FRAME_LEN = NUM_CH * SLOT_W;
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    generate
        if (SLOT_W < AUDIO_DW) begin : g_bad_slot
            $error("tdm_tx: SLOT_W must be >= AUDIO_DW");
        end
        if (NUM_CH < 1) begin : g_bad_ch
            $error("tdm_tx: NUM_CH must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0]           r_bit_cnt;
    logic                       r_run;
    logic                       r_full;
    logic [NUM_CH*AUDIO_DW-1:0] r_hold;
    logic [FRAME_LEN-1:0]       r_shift;
    logic                       r_fsync;
    logic                       r_underrun;
    logic                       r_ready;
    logic                       r_sdata;
`ifdef TDM_TX_I2S_DELAY_EN
    logic                       r_bit_d;
`endif

    logic                       w_last;
    logic                       w_xfer;
    logic                       w_full_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [FRAME_LEN-1:0]       w_frame;
    logic [FRAME_LEN-1:0]       w_src;

    // Frame image of the holding register: slot k starts at frame bit k*SLOT_W, zero padded.
    // NOTE: always_comb assigns a default before any conditional/loop write, so no latch is inferred.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_frame[FRAME_LEN-1-k*SLOT_W -: AUDIO_DW] = r_hold[k*AUDIO_DW +: AUDIO_DW];
        end
    end

    // r_run is low for the one cycle after reset, which opens the first (all-zero) frame without an underrun.
    assign w_last    = r_run && (r_bit_cnt == LAST);
    assign w_xfer    = s_valid && r_ready;
    assign w_cnt_nxt = (!r_run || w_last) ? '0 : r_bit_cnt + 1'b1;
    assign w_src     = w_last ? (r_full ? w_frame : '0) : r_shift;

    // An accept at the load cycle is not bypassed: the old (empty) state decides the load.
    always_comb begin
        w_full_nxt = r_full;
        if (w_xfer) begin
            w_full_nxt = 1'b1;
        end else if (w_last) begin
            w_full_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_run      <= 1'b0;
            r_full     <= 1'b0;
            r_shift    <= '0;
            r_fsync    <= 1'b0;
            r_underrun <= 1'b0;
            r_ready    <= 1'b0;
            r_sdata    <= 1'b0;
`ifdef TDM_TX_I2S_DELAY_EN
            r_bit_d    <= 1'b0;
`endif
        end else begin
            r_run      <= 1'b1;
            r_bit_cnt  <= w_cnt_nxt;
            r_full     <= w_full_nxt;
            r_ready    <= !w_full_nxt;
            r_shift    <= w_src << 1;
            r_fsync    <= !r_run || w_last;
            r_underrun <= w_last && !r_full;
`ifdef TDM_TX_I2S_DELAY_EN
            r_bit_d    <= w_src[FRAME_LEN-1];
            r_sdata    <= r_bit_d;
`else
            r_sdata    <= w_src[FRAME_LEN-1];
`endif
        end
    end

    // NOTE: the holding data path is not reset; r_full alone says whether it holds a valid frame.
    always_ff @(posedge sclk) begin
        if (w_xfer) begin
            r_hold <= s_data;
        end
    end

    assign s_ready     = r_ready;
    assign fsync       = r_fsync;
    assign frame_start = r_fsync;
    assign underrun    = r_underrun;
    assign sdata       = r_sdata;

endmodule

// File: tb/tb_tdm_tx.sv
// tb_tdm_tx: randomized self-checking bench for tdm_tx against a frame-level reference model.
// Build with TDM_TX_I2S_DELAY_EN defined to exercise the I2S delay configuration (2 x 32-bit slots).
module tb_tdm_tx;
`ifdef TDM_TX_I2S_DELAY_EN
    localparam int NUM_CH   = 2;
    localparam int AUDIO_DW = 32;
    localparam int SLOT_W   = 32;
    localparam int DELAY    = 1;
`else
    localparam int NUM_CH   = 4;
    localparam int AUDIO_DW = 16;
    localparam int SLOT_W   = 24;
    localparam int DELAY    = 0;
`endif
    localparam int L  = NUM_CH * SLOT_W;
    localparam int DW = NUM_CH * AUDIO_DW;
`ifdef TDM_TX_I2S_DELAY_EN
    localparam logic [DW-1:0] BASIC_WORD = {32'h89abcdef, 32'h01234567};
`else
    localparam logic [DW-1:0] BASIC_WORD = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
`endif

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, fsync, sdata, frame_start, underrun;

    always #5 sclk = ~sclk;

    tdm_tx #(.AUDIO_DW(AUDIO_DW), .SLOT_W(SLOT_W), .NUM_CH(NUM_CH)) dut (
        .sclk(sclk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fsync(fsync), .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position in frame, holding buffer, and the current frame as a bit list.
    bit            m_started = 0;
    int            m_cnt = 0;
    bit            m_full = 0;
    logic [DW-1:0] m_hold = '0;
    bit            m_frame[L];
    bit            m_prev_last = 0;
    bit            m_xfer = 0;
    bit            e_fsync = 0, e_sdata = 0, e_un = 0, e_ready = 0;
    bit            cap[L];
    logic [DW-1:0] b2b_q[$];

    function automatic bit frame_bit(logic [DW-1:0] w, int c);
        int slot = c / SLOT_W;
        int b = c % SLOT_W;
        if (b >= AUDIO_DW) return 1'b0;
        return w[slot*AUDIO_DW + AUDIO_DW - 1 - b];
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    function automatic logic [AUDIO_DW-1:0] cap_chan(int k);
        logic [AUDIO_DW-1:0] w;
        for (int b = 0; b < AUDIO_DW; b++) w[AUDIO_DW-1-b] = cap[k*SLOT_W + b];
        return w;
    endfunction

    function automatic bit cap_pad(int k);
        bit p = 0;
        for (int b = AUDIO_DW; b < SLOT_W; b++) p |= cap[k*SLOT_W + b];
        return p;
    endfunction

    // Advance the model over one clock edge using the current inputs, then clock the DUT.
    task automatic step();
        int idx;
        m_xfer = 0;
        if (rst) begin
            m_started = 0; m_cnt = 0; m_full = 0; m_prev_last = 0;
            foreach (m_frame[c]) m_frame[c] = 0;
            {e_fsync, e_sdata, e_un, e_ready} = '0;
        end else begin
            if (!m_started) begin
                m_started = 1; m_cnt = 0; e_un = 0;
            end else begin
                m_xfer = s_valid && e_ready;
                if (m_cnt == L - 1) begin
                    m_prev_last = m_frame[L-1];
                    e_un = !m_full;
                    for (int c = 0; c < L; c++) m_frame[c] = m_full ? frame_bit(m_hold, c) : 1'b0;
                    m_full = 0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    e_un = 0;
                end
                if (m_xfer) begin
                    m_full = 1;
                    m_hold = s_data;
                end
            end
            e_ready = !m_full;
            e_fsync = (m_cnt == 0);
            idx = m_cnt - DELAY;
            e_sdata = (idx < 0) ? m_prev_last : m_frame[idx];
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_cnt(int target, bit need_empty);
        int guard = 0;
        while (!(m_cnt == target && (!need_empty || !m_full)) && guard < 4*L) begin
            step();
            guard++;
        end
        if (guard >= 4*L) begin
            n_vec++; n_err++;
            $display("FAIL wait_cnt: position %0d not reached within %0d cycles", target, 4*L);
        end
    endtask

    // Waits for the next fsync and collects one frame's bits into cap[] (honouring the I2S delay).
    task automatic capture(output bit un_fs);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (fsync !== 1'b1 && guard < 2*L);
        if (fsync !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL capture: no fsync within %0d cycles", 2*L);
        end
        un_fs = underrun;
        if (DELAY == 0) cap[0] = sdata;
        for (int j = (DELAY == 0) ? 1 : 0; j < L; j++) begin
            step();
            cap[j] = sdata;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if ({fsync, sdata, frame_start, underrun, s_ready} !== 5'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b required 00000",
                         {fsync, sdata, frame_start, underrun, s_ready});
            end
        end
    endtask

    task automatic test_idle();
        int n_fs = 0, n_un = 0, n_ones = 0;
        rst = 1'b0;
        for (int i = 0; i < 3*L; i++) begin
            step();
            n_vec++;
            if ({fsync, sdata, frame_start, underrun, s_ready} !== {e_fsync, e_sdata, e_fsync, e_un, e_ready}) begin
                n_err++;
                $display("FAIL idle_cycle%0d: got %b required %b", i,
                         {fsync, sdata, frame_start, underrun, s_ready},
                         {e_fsync, e_sdata, e_fsync, e_un, e_ready});
            end
            if (i == 0 && s_ready !== 1'b1) begin
                n_err++;
                $display("FAIL idle_first_ready: got %b required 1", s_ready);
            end
            n_fs += int'(fsync === 1'b1);
            n_un += int'(underrun === 1'b1);
            n_ones += int'(sdata !== 1'b0);
        end
        n_vec += 3;
        if (n_fs != 3) begin n_err++; $display("FAIL idle_fsync_count: got %0d required 3", n_fs); end
        if (n_un != 2) begin n_err++; $display("FAIL idle_underrun_count: got %0d required 2", n_un); end
        if (n_ones != 0) begin n_err++; $display("FAIL idle_sdata_ones: got %0d required 0", n_ones); end
    endtask

    task automatic test_basic();
        bit un_fs;
        wait_cnt(10, 1'b1);
        s_valid = 1'b1;
        s_data = BASIC_WORD;
        step();
        s_valid = 1'b0;
        s_data = rand_word();
        n_vec++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_low: got %b required 0", s_ready); end
        capture(un_fs);
        n_vec++;
        if (un_fs !== 1'b0) begin n_err++; $display("FAIL basic_underrun: got %b required 0", un_fs); end
        for (int k = 0; k < NUM_CH; k++) begin
            n_vec++;
            if (cap_chan(k) !== BASIC_WORD[k*AUDIO_DW +: AUDIO_DW] || cap_pad(k) !== 1'b0) begin
                n_err++;
                $display("FAIL basic_ch%0d: got %h pad %b required %h pad 0", k, cap_chan(k), cap_pad(k),
                         BASIC_WORD[k*AUDIO_DW +: AUDIO_DW]);
            end
        end
    endtask

    task automatic check_b2b_frame();
        logic [DW-1:0] exp_w;
        if (b2b_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b2b_frame: frame transmitted with no word queued");
            return;
        end
        exp_w = b2b_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            n_vec++;
            if (cap_chan(k) !== exp_w[k*AUDIO_DW +: AUDIO_DW] || cap_pad(k) !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ch%0d: got %h pad %b required %h pad 0", k, cap_chan(k), cap_pad(k),
                         exp_w[k*AUDIO_DW +: AUDIO_DW]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int frames = 0, n_un = 0, guard = 0, t = 0;
        bit open = 0;
        b2b_q.delete();
        wait_cnt(4, 1'b1);
        s_valid = 1'b1;
        s_data = rand_word();
        while (frames < 4 && guard < 6*L) begin
            step();
            guard++;
            if (m_xfer) begin
                b2b_q.push_back(m_hold);
                n_vec++;
                if (s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_accept: got %b required 0", s_ready); end
                s_data = rand_word();
            end
            if (fsync === 1'b1) begin
                n_un += int'(underrun !== 1'b0);
                if (DELAY == 1 && open) begin
                    cap[L-1] = sdata;
                    check_b2b_frame();
                    frames++;
                end
                open = 1;
                t = 0;
            end else begin
                t++;
            end
            if (open && t >= DELAY && t - DELAY < L) begin
                cap[t - DELAY] = sdata;
                if (DELAY == 0 && t == L - 1) begin
                    check_b2b_frame();
                    frames++;
                    open = 0;
                end
            end
        end
        s_valid = 1'b0;
        n_vec += 3;
        if (frames != 4) begin n_err++; $display("FAIL b2b_frames: got %0d required 4", frames); end
        if (n_un != 0) begin n_err++; $display("FAIL b2b_underruns: got %0d required 0", n_un); end
        if (b2b_q.size() != 1) begin n_err++; $display("FAIL b2b_pending: got %0d required 1", b2b_q.size()); end
    endtask

    task automatic test_late_valid();
        logic [DW-1:0] w;
        bit un_fs;
        int n_ones = 0;
        w = rand_word();
        wait_cnt(L - 2, 1'b1);
        step();
        s_valid = 1'b1;
        s_data = w;
        step();
        s_valid = 1'b0;
        s_data = rand_word();
        n_vec += 2;
        if ({fsync, underrun} !== 2'b11) begin n_err++; $display("FAIL late_underrun: got fsync,underrun=%b required 11", {fsync, underrun}); end
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL late_captured: got s_ready=%b required 0", s_ready); end
        if (DELAY == 0) n_ones += int'(sdata !== 1'b0);
        for (int i = 1; i < L; i++) begin
            step();
            n_ones += int'(sdata !== 1'b0);
        end
        n_vec++;
        if (n_ones != 0) begin n_err++; $display("FAIL late_zero_frame: got %0d ones required 0", n_ones); end
        capture(un_fs);
        n_vec++;
        if (un_fs !== 1'b0) begin n_err++; $display("FAIL late_next_underrun: got %b required 0", un_fs); end
        for (int k = 0; k < NUM_CH; k++) begin
            n_vec++;
            if (cap_chan(k) !== w[k*AUDIO_DW +: AUDIO_DW]) begin
                n_err++;
                $display("FAIL late_ch%0d: got %h required %h", k, cap_chan(k), w[k*AUDIO_DW +: AUDIO_DW]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_fs = 0, n_un = 0, n_ones = 0;
        wait_cnt(2, 1'b1);
        s_valid = 1'b1;
        s_data = rand_word() | DW'(1);
        step();
        s_valid = 1'b0;
        n_vec++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_full: got s_ready=%b required 0", s_ready); end
        wait_cnt(40, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if ({fsync, sdata, s_ready, underrun, frame_start} !== 5'b0) begin
                n_err++;
                $display("FAIL rstmid_in_reset%0d: got %b required 00000", i, {fsync, sdata, s_ready, underrun, frame_start});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2*L; i++) begin
            step();
            n_fs += int'(fsync === 1'b1);
            n_un += int'(underrun === 1'b1);
            n_ones += int'(sdata !== 1'b0);
        end
        n_vec += 3;
        if (n_fs != 2) begin n_err++; $display("FAIL rstmid_fsync_count: got %0d required 2", n_fs); end
        if (n_un != 1) begin n_err++; $display("FAIL rstmid_underrun_count: got %0d required 1", n_un); end
        if (n_ones != 0) begin n_err++; $display("FAIL rstmid_discarded: got %0d ones required 0", n_ones); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6*L; i++) begin
            s_valid = ($urandom_range(0, 5) == 0);
            if (s_valid) s_data = rand_word();
            rst = (i >= 3*L + 17 && i < 3*L + 20);
            step();
            n_vec++;
            if ({fsync, sdata, frame_start, underrun, s_ready} !== {e_fsync, e_sdata, e_fsync, e_un, e_ready}) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %b required %b", i,
                         {fsync, sdata, frame_start, underrun, s_ready},
                         {e_fsync, e_sdata, e_fsync, e_un, e_ready});
            end
        end
        rst = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_back_to_back();
        test_late_valid();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
